dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 19 +
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
// Round-robin arbitration is enabled by defining DMEM_ARB_RR_EN.
package dmem_arb_pkg;

    localparam int unsigned DefaultDw = 32;
    localparam int unsigned DefaultAw = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arbState_e;

    typedef logic portId_t;

    localparam portId_t Port0 = 1'b0;
    localparam portId_t Port1 = 1'b1;

    // Converts a 2-bit one-hot grant into a port id (all-zero maps to Port0).
    function automatic portId_t oneHotToId(input logic [1:0] oneHot);
        return portId_t'(oneHot[1] & ~oneHot[0]);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester winner selection: a lone requester wins, a tie goes to the
// port that was not served last.
module rr_arb2 import dmem_arb_pkg::*; (
    input  logic [1:0] req,
    input  portId_t    lastServed,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (lastServed == Port1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: one access per two cycles, reads return one
// cycle after grant. Define DMEM_ARB_RR_EN for round-robin ties (else port 0 wins).
module dmem_arbiter import dmem_arb_pkg::*; #(
    parameter int unsigned DW        = DefaultDw,
    parameter int unsigned AW        = DefaultAw,
    parameter int unsigned WORD_ADDR = 1
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,

    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wr,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_rdata
);

    arbState_e     stateQ, stateD;
    portId_t       ownerQ, ownerD;
    portId_t       lastServed;
    logic [1:0]    reqVec;
    logic [1:0]    grantVec;
    logic          ownerReq;
    logic          ownerWe;
    logic [AW-1:0] ownerAddr;
    logic [DW-1:0] ownerWdata;
    logic          access;
    logic [1:0]    rvalidQ;
    logic [DW-1:0] rdata0Q, rdata1Q;

    assign reqVec = {req1, req0};

    rr_arb2 uArb (
        .req        (reqVec),
        .lastServed (lastServed),
        .grant      (grantVec)
    );

    assign ownerReq   = (ownerQ == Port1) ? req1   : req0;
    assign ownerWe    = (ownerQ == Port1) ? we1    : we0;
    assign ownerAddr  = (ownerQ == Port1) ? addr1  : addr0;
    assign ownerWdata = (ownerQ == Port1) ? wdata1 : wdata0;

    // An access happens only if the owner still requests and reset is not aborting it.
    assign access = (stateQ == SERVE) && ownerReq && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= IDLE;
            ownerQ <= Port0;
        end else begin
            stateQ <= stateD;
            ownerQ <= ownerD;
        end
    end

    always_comb begin
        stateD = stateQ;
        ownerD = ownerQ;
        unique case (stateQ)
            IDLE: begin
                if (|reqVec) begin
                    stateD = SERVE;
                    ownerD = oneHotToId(grantVec);
                end
            end
            SERVE: stateD = IDLE;
        endcase
    end

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (access) begin
            mem_addr  = (WORD_ADDR != 0) ? (ownerAddr >> 2) : ownerAddr;
            mem_wdata = ownerWdata;
            mem_wr    = ownerWe;
            mem_rd    = !ownerWe;
            gnt0      = (ownerQ == Port0);
            gnt1      = (ownerQ == Port1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalidQ <= 2'b00;
            rdata0Q <= '0;
            rdata1Q <= '0;
        end else begin
            rvalidQ <= 2'b00;
            if (mem_rd) begin
                rvalidQ[ownerQ] <= 1'b1;
                if (ownerQ == Port1) begin
                    rdata1Q <= mem_rdata;
                end else begin
                    rdata0Q <= mem_rdata;
                end
            end
        end
    end

`ifdef DMEM_ARB_RR_EN
    portId_t lastQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            lastQ <= Port1;
        end else if (gnt0 || gnt1) begin
            lastQ <= ownerQ;
        end
    end

    assign lastServed = lastQ;
`else
    // Pretending port 1 was always served last makes port 0 win every tie.
    assign lastServed = Port1;
`endif

    assign rvalid0 = rvalidQ[0];
    assign rvalid1 = rvalidQ[1];
    assign rdata0  = rdata0Q;
    assign rdata1  = rdata1Q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then randomized
// two-port traffic against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wr, mem_rd;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.DW(DW), .AW(AW), .WORD_ADDR(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .gnt0      (gnt0),
        .rvalid0   (rvalid0),
        .rdata0    (rdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt1      (gnt1),
        .rvalid1   (rvalid1),
        .rdata1    (rdata1),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr    (mem_wr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata)
    );

    // Device memory seen by the DUT (word indexed, 256 words).
    logic [DW-1:0] devMem [256];
    assign mem_rdata = devMem[mem_addr[7:0]];
    always @(posedge clk) if (mem_wr) devMem[mem_addr[7:0]] <= mem_wdata;

    int total = 0;
    int bad   = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: arbiter is either free or committed to one pending access.
    bit            busy;
    bit            who;
    bit            last = 1'b1;
    logic [1:0]    expRv = 2'b00;
    logic [1:0]    granted = 2'b00;
    logic [DW-1:0] expRdata [2];
    logic [DW-1:0] refMem [256];

    function automatic bit tieWin();
`ifdef DMEM_ARB_RR_EN
        return !last;
`else
        return 1'b0;
`endif
    endfunction

    task automatic modelStep();
        logic [1:0]    rq, wv, eG, nRv;
        logic [AW-1:0] av [2];
        logic [DW-1:0] dv [2];
        logic          eWr, eRd;
        int            idx;
        rq = {req1, req0};
        wv = {we1, we0};
        av[0] = addr0; av[1] = addr1;
        dv[0] = wdata0; dv[1] = wdata1;
        eG = 2'b00; eWr = 1'b0; eRd = 1'b0;
        if (busy && rq[who] && !rst) begin
            eG[who] = 1'b1;
            eWr = wv[who];
            eRd = !wv[who];
        end
        checkVal("gnt0", gnt0, eG[0]);
        checkVal("gnt1", gnt1, eG[1]);
        checkVal("mem_wr", mem_wr, eWr);
        checkVal("mem_rd", mem_rd, eRd);
        checkVal("rvalid0", rvalid0, expRv[0]);
        checkVal("rvalid1", rvalid1, expRv[1]);
        checkVal("rdata0", rdata0, expRdata[0]);
        checkVal("rdata1", rdata1, expRdata[1]);
        if (eWr || eRd) checkVal("mem_addr", mem_addr, av[who] >> 2);
        else            checkVal("mem_addr_off", mem_addr, 0);
        if (eWr) checkVal("mem_wdata", mem_wdata, dv[who]);
        checkVal("gnt_excl", gnt0 & gnt1, 0);
        checkVal("wr_rd_excl", mem_wr & mem_rd, 0);

        nRv = 2'b00;
        granted = eG;
        if (rst) begin
            busy = 1'b0;
            last = 1'b1;
            expRdata[0] = '0;
            expRdata[1] = '0;
        end else if (busy) begin
            busy = 1'b0;
            if (eG != 2'b00) begin
                idx = int'((av[who] >> 2) & 32'hff);
                if (eWr) refMem[idx] = dv[who];
                else begin
                    expRdata[who] = refMem[idx];
                    nRv[who] = 1'b1;
                end
                last = who;
            end
        end else if (rq != 2'b00) begin
            busy = 1'b1;
            who  = (rq == 2'b11) ? tieWin() : rq[1];
        end
        expRv = nRv;
    endtask

    task automatic evalCycle();
        @(negedge clk);
        modelStep();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Random requesters: hold each access until granted, occasionally abandon it.
    bit            on [2];
    bit            wr [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];

    task automatic newTxn(input int p);
        wr[p] = 1'($urandom_range(0, 1));
        ad[p] = AW'($urandom_range(0, 63));
        wd[p] = DW'($urandom);
    endtask

    task automatic driveRandom();
        for (int p = 0; p < 2; p++) begin
            if (granted[p]) begin
                on[p] = ($urandom_range(0, 99) < 50);
                if (on[p]) newTxn(p);
            end else if (!on[p]) begin
                if ($urandom_range(0, 99) < 35) begin
                    on[p] = 1'b1;
                    newTxn(p);
                end
            end else if ($urandom_range(0, 99) < 4) begin
                on[p] = 1'b0;
            end
        end
        rst    = ($urandom_range(0, 99) < 2);
        req0   = on[0]; we0 = wr[0]; addr0 = ad[0]; wdata0 = wd[0];
        req1   = on[1]; we1 = wr[1]; addr1 = ad[1]; wdata1 = wd[1];
    endtask

    bit   tieSeq [$];
    logic [3:0] expTie;

    initial begin
        for (int i = 0; i < 256; i++) begin
            devMem[i] = '0;
            refMem[i] = '0;
        end
        expRdata[0] = '0;
        expRdata[1] = '0;
        rst = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        advance();
        evalCycle();
        checkVal("rst_rdata0", rdata0, 0);
        checkVal("rst_rvalid1", rvalid1, 0);
        advance();
        rst = 1'b0;

        // Single write from port 0.
        req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
        evalCycle(); advance();
        evalCycle();
        checkVal("wr_gnt0", gnt0, 1);
        checkVal("wr_addr", mem_addr, 32'h4);
        checkVal("wr_en", mem_wr, 1);
        advance();
        req0 = 0;

        // Read-back from port 1.
        req1 = 1; we1 = 0; addr1 = 32'h10;
        evalCycle(); advance();
        evalCycle();
        checkVal("rd_gnt1", gnt1, 1);
        advance();
        req1 = 0;
        evalCycle();
        checkVal("rd_rvalid1", rvalid1, 1);
        checkVal("rd_rdata1", rdata1, 32'hDEADBEEF);
        advance();

        // Tie with both requests held.
        rst = 1; evalCycle(); advance(); rst = 0;
        req0 = 1; we0 = 0; addr0 = 32'h10;
        req1 = 1; we1 = 0; addr1 = 32'h14;
        for (int c = 0; c < 8; c++) begin
            evalCycle();
            if (gnt0 || gnt1) tieSeq.push_back(gnt1);
            advance();
        end
        req0 = 0; req1 = 0;
`ifdef DMEM_ARB_RR_EN
        expTie = 4'b1010;
`else
        expTie = 4'b0000;
`endif
        checkVal("tie_count", tieSeq.size(), 4);
        for (int k = 0; k < 4 && k < tieSeq.size(); k++) checkVal("tie_order", tieSeq[k], expTie[k]);

        // Reset during the access cycle of a write aborts it.
        req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h11112222;
        evalCycle(); advance(); evalCycle(); advance();
        wdata0 = 32'h33334444;
        evalCycle(); advance();
        rst = 1;
        evalCycle();
        checkVal("abort_wr", mem_wr, 0);
        checkVal("abort_gnt", gnt0, 0);
        advance();
        rst = 0; req0 = 0;
        evalCycle(); advance();
        req1 = 1; we1 = 0; addr1 = 32'h20;
        evalCycle(); advance(); evalCycle(); advance();
        req1 = 0;
        evalCycle();
        checkVal("abort_old", rdata1, 32'h11112222);
        advance();

        // Owner withdraws its request in the access cycle.
        req0 = 1; we0 = 0; addr0 = 32'h8;
        evalCycle(); advance();
        req0 = 0;
        evalCycle();
        checkVal("drop_gnt", gnt0, 0);
        checkVal("drop_rd", mem_rd | mem_wr, 0);
        advance();
        req1 = 1; we1 = 1; addr1 = 32'h30; wdata1 = 32'hCAFEF00D;
        evalCycle(); advance();
        evalCycle();
        checkVal("drop_idle", gnt1, 1);
        advance();
        req1 = 0;

        // Randomized traffic.
        on[0] = 0; on[1] = 0;
        granted = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            driveRandom();
            evalCycle();
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
